// File: rtl/key_debounce_pkg.sv
// Shared constants for the push-button debounce stage: key polarity and
// default cycle counts for a 50 MHz clock.
package key_debounce_pkg;

  localparam logic KEY_ACTIVE = 1'b0;
  localparam logic KEY_IDLE   = 1'b1;

  localparam int DEBOUNCE_20MS_50M = 1_000_000;
  localparam int HOLD_1S_50M       = 50_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce counter, press/release
// strobes and a saturating long-press counter.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50M,
  parameter int HOLD_CYCLES     = HOLD_1S_50M
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic key,
  output logic key_clean,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic          sync1, sync2;
  logic [DW-1:0] db_cnt, db_cnt_next;
  logic [HW-1:0] hold_cnt, hold_cnt_next;
  logic          clean_next, press_next, release_next, hold_next;

  always_comb begin
    db_cnt_next   = db_cnt;
    clean_next    = key_clean;
    press_next    = 1'b0;
    release_next  = 1'b0;
    hold_cnt_next = hold_cnt;

    // Any cycle where the synchronised level agrees with the output restarts the count.
    if (sync2 == key_clean) begin
      db_cnt_next = '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt_next  = '0;
      clean_next   = sync2;
      press_next   = (sync2 == KEY_ACTIVE);
      release_next = (sync2 == KEY_IDLE);
    end else begin
      db_cnt_next = db_cnt + DW'(1);
    end

    if (key_clean == KEY_IDLE) begin
      hold_cnt_next = '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt_next = hold_cnt + HW'(1);
    end

    // Gate with the next clean level so hold drops on the same edge the release strobe rises.
    hold_next = (clean_next == KEY_ACTIVE) && (hold_cnt_next == HOLD_MAX);
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sync1       <= KEY_IDLE;
      sync2       <= KEY_IDLE;
      key_clean   <= KEY_IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_hold    <= 1'b0;
    end else begin
      sync1       <= key;
      sync2       <= sync1;
      key_clean   <= clean_next;
      db_cnt      <= db_cnt_next;
      hold_cnt    <= hold_cnt_next;
      key_press   <= press_next;
      key_release <= release_next;
      key_hold    <= hold_next;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS raw active-low push-buttons into clean levels, edge
// strobes and long-press flags; every key is an independent channel.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50M,
  parameter int HOLD_CYCLES     = HOLD_1S_50M
) (
  input  logic                clk_50M,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_clean,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk_50M    (clk_50M),
      .rst        (rst),
      .key        (key[i]),
      .key_clean  (key_clean[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_hold   (key_hold[i])
    );
  end

endmodule
